// File: rtl/sb_pkg.sv
// ============================================================================
// Module  : sb_pkg
// Brief   : Shared types and sizing helpers for the mc_scoreboard block.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        TRACK = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Occupancy/position counters must represent the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mc_scoreboard_if.sv
// ============================================================================
// Module  : mc_scoreboard_if
// Brief   : Observation bus between a multi-channel FIFO bank and its scoreboard.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_scoreboard_if
    import sb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int CHW    = ch_w(NUM_CH)
);

    logic                    start;
    logic [CHW-1:0]          start_ch;
    logic [NUM_CH-1:0]       push;
    logic [NUM_CH-1:0]       pop;
    logic [NUM_CH*WIDTH-1:0] flat_data_in;
    logic [NUM_CH*WIDTH-1:0] flat_data_out;
    logic [NUM_CH-1:0]       chk_vld;
    logic [NUM_CH-1:0]       chk_err;
    logic [NUM_CH-1:0]       proto_err;
    logic                    busy;
    logic                    prop_signal;

    modport master (
        output start, start_ch, push, pop, flat_data_in, flat_data_out,
        input  chk_vld, chk_err, proto_err, busy, prop_signal
    );

    modport slave (
        input  start, start_ch, push, pop, flat_data_in, flat_data_out,
        output chk_vld, chk_err, proto_err, busy, prop_signal
    );

endinterface

`default_nettype wire

// File: rtl/sb_channel.sv
// ============================================================================
// Module  : sb_channel
// Brief   : One observed channel: occupancy tracking, magic-packet FSM, checks.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_channel
    import sb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int REARM = 0
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_start_hit,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data_in,
    input  wire logic [WIDTH-1:0] i_data_out,
    output logic                  o_chk_vld,
    output logic                  o_chk_err,
    output logic                  o_proto_err,
    output logic                  o_busy
);

    localparam int c_CNTW = cnt_w(DEPTH);
    localparam logic [c_CNTW-1:0] c_FULL = c_CNTW'(DEPTH);
    localparam logic [c_CNTW-1:0] c_ONE  = c_CNTW'(1);

    localparam logic [1:0] c_ST_IDLE  = IDLE;
    localparam logic [1:0] c_ST_WAIT  = WAIT;
    localparam logic [1:0] c_ST_TRACK = TRACK;
    localparam logic [1:0] c_ST_DONE  = DONE;

    logic [1:0]        r_state;
    logic [c_CNTW-1:0] r_occ;
    logic [c_CNTW-1:0] r_pos;
    logic [WIDTH-1:0]  r_magic;
    logic              r_chk_vld;
    logic              r_chk_err;
    logic              r_proto_err;

    logic              w_push_bad;
    logic              w_pop_bad;
    logic              w_push_ok;
    logic [c_CNTW-1:0] w_cap_pos;

    // A simultaneous push and pop is always legal, even at the occupancy limits.
    assign w_push_bad = i_push & ~i_pop & (r_occ == c_FULL);
    assign w_pop_bad  = i_pop & ~i_push & (r_occ == '0);
    assign w_push_ok  = i_push & ~w_push_bad;
    assign w_cap_pos  = r_occ - c_CNTW'(i_pop) + c_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_occ       <= '0;
            r_pos       <= '0;
            r_magic     <= '0;
            r_chk_vld   <= 1'b0;
            r_chk_err   <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_chk_vld <= 1'b0;

            if (w_push_bad || w_pop_bad) begin
                r_proto_err <= 1'b1;
            end

            if (i_push && !i_pop && !w_push_bad) begin
                r_occ <= r_occ + c_ONE;
            end else if (i_pop && !i_push && !w_pop_bad) begin
                r_occ <= r_occ - c_ONE;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (i_start_hit) begin
                        if (w_push_ok) begin
                            r_magic <= i_data_in;
                            r_pos   <= w_cap_pos;
                            r_state <= c_ST_TRACK;
                        end else begin
                            r_state <= c_ST_WAIT;
                        end
                    end
                end
                c_ST_WAIT: begin
                    if (w_push_ok) begin
                        r_magic <= i_data_in;
                        r_pos   <= w_cap_pos;
                        r_state <= c_ST_TRACK;
                    end
                end
                c_ST_TRACK: begin
                    // The packet only reaches the head after the capture cycle.
                    if (i_pop) begin
                        if (r_pos == c_ONE) begin
                            r_chk_vld <= 1'b1;
                            if (i_data_out != r_magic) begin
                                r_chk_err <= 1'b1;
                            end
                            r_state <= c_ST_DONE;
                        end else begin
                            r_pos <= r_pos - c_ONE;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (REARM != 0) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign o_chk_vld   = r_chk_vld;
    assign o_chk_err   = r_chk_err;
    assign o_proto_err = r_proto_err;
    assign o_busy      = (r_state == c_ST_WAIT) || (r_state == c_ST_TRACK);

endmodule

`default_nettype wire

// File: rtl/mc_scoreboard.sv
// ============================================================================
// Module  : mc_scoreboard
// Brief   : Passive magic-packet scoreboard across NUM_CH parallel FIFO channels.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_scoreboard
    import sb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int WIDTH  = 8,
    parameter int REARM  = 0,
    parameter int CHW    = ch_w(NUM_CH)
) (
    input wire logic       clk,
    input wire logic       rst,
    mc_scoreboard_if.slave bus
);

    logic [NUM_CH-1:0] w_start_hit;
    logic [NUM_CH-1:0] w_chk_vld;
    logic [NUM_CH-1:0] w_chk_err;
    logic [NUM_CH-1:0] w_proto_err;
    logic [NUM_CH-1:0] w_busy;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign w_start_hit[c] = bus.start && (bus.start_ch == CHW'(c));

        sb_channel #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH),
            .REARM (REARM)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .i_start_hit (w_start_hit[c]),
            .i_push      (bus.push[c]),
            .i_pop       (bus.pop[c]),
            .i_data_in   (bus.flat_data_in[c*WIDTH +: WIDTH]),
            .i_data_out  (bus.flat_data_out[c*WIDTH +: WIDTH]),
            .o_chk_vld   (w_chk_vld[c]),
            .o_chk_err   (w_chk_err[c]),
            .o_proto_err (w_proto_err[c]),
            .o_busy      (w_busy[c])
        );
    end

    assign bus.chk_vld     = w_chk_vld;
    assign bus.chk_err     = w_chk_err;
    assign bus.proto_err   = w_proto_err;
    assign bus.busy        = |w_busy;
    assign bus.prop_signal = ~|w_chk_err & ~|w_proto_err;

endmodule

`default_nettype wire

// File: tb/tb_mc_scoreboard.sv
// ============================================================================
// Module  : tb_mc_scoreboard
// Brief   : Directed vector bench for mc_scoreboard (REARM=0 and REARM=1 copies).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_scoreboard;

    typedef struct {
        logic        rst;
        logic        start;
        logic [1:0]  sch;
        logic [3:0]  push;
        logic [3:0]  pop;
        logic [31:0] din;
        logic [31:0] dout;
        logic [3:0]  vld;
        logic [3:0]  err;
        logic [3:0]  perr;
        logic        busy;
        logic        prop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mc_scoreboard_if #(.NUM_CH(4), .WIDTH(8)) bus_a ();
    mc_scoreboard_if #(.NUM_CH(4), .WIDTH(8)) bus_b ();

    mc_scoreboard #(.NUM_CH(4), .DEPTH(8), .WIDTH(8), .REARM(0)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a.slave)
    );

    mc_scoreboard #(.NUM_CH(4), .DEPTH(8), .WIDTH(8), .REARM(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b.slave)
    );

    task automatic add(input logic r, input logic st, input logic [1:0] sc,
                       input logic [3:0] pu, input logic [3:0] po,
                       input logic [31:0] di, input logic [31:0] dq,
                       input logic [3:0] vl, input logic [3:0] er, input logic [3:0] pe,
                       input logic bz, input logic pr);
        vec_t t;
        t.rst = r;  t.start = st; t.sch = sc; t.push = pu; t.pop = po;
        t.din = di; t.dout = dq;  t.vld = vl; t.err = er; t.perr = pe;
        t.busy = bz; t.prop = pr;
        tbl.push_back(t);
    endtask

    // Drives one vector on the selected copy, idles the other, checks after the edge.
    task automatic apply(input bit sel, input vec_t t, input string tag);
        logic [3:0] g_vld, g_err, g_perr;
        logic       g_busy, g_prop;
        @(negedge clk);
        if (!sel) begin
            rst_a = t.rst; bus_a.start = t.start; bus_a.start_ch = t.sch;
            bus_a.push = t.push; bus_a.pop = t.pop;
            bus_a.flat_data_in = t.din; bus_a.flat_data_out = t.dout;
            bus_b.start = 1'b0; bus_b.push = '0; bus_b.pop = '0;
        end else begin
            rst_b = t.rst; bus_b.start = t.start; bus_b.start_ch = t.sch;
            bus_b.push = t.push; bus_b.pop = t.pop;
            bus_b.flat_data_in = t.din; bus_b.flat_data_out = t.dout;
            bus_a.start = 1'b0; bus_a.push = '0; bus_a.pop = '0;
        end
        @(posedge clk);
        #1;
        if (!sel) begin
            g_vld = bus_a.chk_vld; g_err = bus_a.chk_err; g_perr = bus_a.proto_err;
            g_busy = bus_a.busy; g_prop = bus_a.prop_signal;
        end else begin
            g_vld = bus_b.chk_vld; g_err = bus_b.chk_err; g_perr = bus_b.proto_err;
            g_busy = bus_b.busy; g_prop = bus_b.prop_signal;
        end
        n_vec++;
        if (g_vld !== t.vld || g_err !== t.err || g_perr !== t.perr ||
            g_busy !== t.busy || g_prop !== t.prop) begin
            n_bad++;
            $display("FAIL %s: got vld=%h err=%h perr=%h busy=%b prop=%b, want vld=%h err=%h perr=%h busy=%b prop=%b",
                     tag, g_vld, g_err, g_perr, g_busy, g_prop,
                     t.vld, t.err, t.perr, t.busy, t.prop);
        end
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bus_a.start = 1'b0; bus_a.start_ch = '0; bus_a.push = '0; bus_a.pop = '0;
        bus_a.flat_data_in = '0; bus_a.flat_data_out = '0;
        bus_b.start = 1'b0; bus_b.start_ch = '0; bus_b.push = '0; bus_b.pop = '0;
        bus_b.flat_data_in = '0; bus_b.flat_data_out = '0;

        // Reset state
        add(1, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        // Match on ch2: occ=3, capture 0xA5 at pos 4, exit on the 4th pop
        add(0, 0, 0, 4'h4, 4'h0, 32'h0011_0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h4, 4'h0, 32'h0022_0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h4, 4'h0, 32'h0033_0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 1, 2, 4'h4, 4'h0, 32'h00A5_0000, 32'h0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h4, 32'h0, 32'h0011_0000, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h4, 32'h0, 32'h0022_0000, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h4, 32'h0, 32'h0033_0000, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h4, 32'h0, 32'h00A5_0000, 4'h4, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        // REARM=0: a second start on the finished channel is ignored
        add(0, 1, 2, 4'h4, 4'h0, 32'h0042_0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        // Mismatch on ch2: sticky chk_err, prop_signal low
        add(1, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h4, 4'h0, 32'h0011_0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h4, 4'h0, 32'h0022_0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h4, 4'h0, 32'h0033_0000, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 1, 2, 4'h4, 4'h0, 32'h00A5_0000, 32'h0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h4, 32'h0, 32'h0011_0000, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h4, 32'h0, 32'h0022_0000, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h4, 32'h0, 32'h0033_0000, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h4, 32'h0, 32'h005A_0000, 4'h4, 4'h4, 4'h0, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h4, 4'h0, 0, 0);
        add(0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h4, 4'h0, 0, 0);
        // Overflow on ch0, underflow on ch1
        add(1, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        for (int i = 0; i < 8; i++)
            add(0, 0, 0, 4'h1, 4'h0, 32'(i + 1), 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h1, 4'h0, 32'h0000_00FF, 32'h0, 4'h0, 4'h0, 4'h1, 0, 0);
        add(0, 0, 0, 4'h0, 4'h2, 32'h0, 32'h0, 4'h0, 4'h0, 4'h3, 0, 0);
        add(0, 0, 0, 4'h1, 4'h1, 32'h0000_0009, 32'h0000_0001, 4'h0, 4'h0, 4'h3, 0, 0);
        // occ held at 8: push+pop capture lands at pos 8, exits on the 8th pop
        add(0, 1, 0, 4'h1, 4'h1, 32'h0000_00EE, 32'h0000_0002, 4'h0, 4'h0, 4'h3, 1, 0);
        for (int i = 0; i < 7; i++)
            add(0, 0, 0, 4'h0, 4'h1, 32'h0, 32'(i + 3), 4'h0, 4'h0, 4'h3, 1, 0);
        add(0, 0, 0, 4'h0, 4'h1, 32'h0, 32'h0000_00EE, 4'h1, 4'h0, 4'h3, 0, 0);
        // Capture on ch1 at occ=1 with simultaneous pop -> pos=1
        add(1, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h2, 4'h0, 32'h0000_7700, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 1, 1, 4'h2, 4'h2, 32'h0000_C300, 32'h0000_7700, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h2, 32'h0, 32'h0000_C300, 4'h2, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        // Reset while ch0 tracks at pos 4 aborts with no check pulse
        add(1, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h1, 4'h0, 32'h0000_0001, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h1, 4'h0, 32'h0000_0002, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 0, 0, 4'h1, 4'h0, 32'h0000_0003, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 1, 0, 4'h1, 4'h0, 32'h0000_0099, 32'h0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(1, 0, 0, 4'h0, 4'h1, 32'h0, 32'h0000_0001, 4'h0, 4'h0, 4'h0, 0, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 4'h1, 4'h0, 32'h0000_0099, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        for (int i = 0; i < 4; i++)
            add(0, 0, 0, 4'h0, 4'h1, 32'h0, 32'h0000_0099, 4'h0, 4'h0, 4'h0, 0, 1);
        // ch0 and ch3 tracking concurrently; ch3 exits with wrong data
        add(1, 0, 0, 4'h0, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 4'h0, 0, 1);
        add(0, 1, 0, 4'h9, 4'h0, 32'h3000_0010, 32'h0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 1, 3, 4'h8, 4'h0, 32'h3100_0000, 32'h0, 4'h0, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h9, 32'h0, 32'h3000_0010, 4'h1, 4'h0, 4'h0, 1, 1);
        add(0, 0, 0, 4'h0, 4'h8, 32'h0, 32'h3200_0000, 4'h8, 4'h8, 4'h0, 0, 0);

        foreach (tbl[i]) apply(1'b0, tbl[i], $sformatf("vecA[%0d]", i));

        // REARM=1 copy: ch3 returns to IDLE after a check and captures again
        begin
            vec_t t;
            t = '{rst:1, start:0, sch:0, push:4'h0, pop:4'h0, din:32'h0, dout:32'h0,
                  vld:4'h0, err:4'h0, perr:4'h0, busy:0, prop:1};
            apply(1'b1, t, "rearm_reset");
            t = '{rst:0, start:1, sch:3, push:4'h8, pop:4'h0, din:32'h1100_0000, dout:32'h0,
                  vld:4'h0, err:4'h0, perr:4'h0, busy:1, prop:1};
            apply(1'b1, t, "rearm_cap1");
            t = '{rst:0, start:0, sch:0, push:4'h0, pop:4'h8, din:32'h0, dout:32'h1100_0000,
                  vld:4'h8, err:4'h0, perr:4'h0, busy:0, prop:1};
            apply(1'b1, t, "rearm_exit1");
            t = '{rst:0, start:0, sch:0, push:4'h0, pop:4'h0, din:32'h0, dout:32'h0,
                  vld:4'h0, err:4'h0, perr:4'h0, busy:0, prop:1};
            apply(1'b1, t, "rearm_done");
            t = '{rst:0, start:1, sch:3, push:4'h8, pop:4'h0, din:32'h3C00_0000, dout:32'h0,
                  vld:4'h0, err:4'h0, perr:4'h0, busy:1, prop:1};
            apply(1'b1, t, "rearm_cap2");
            t = '{rst:0, start:0, sch:0, push:4'h0, pop:4'h8, din:32'h0, dout:32'h3C00_0000,
                  vld:4'h8, err:4'h0, perr:4'h0, busy:0, prop:1};
            apply(1'b1, t, "rearm_exit2");
            t = '{rst:0, start:0, sch:0, push:4'h0, pop:4'h0, din:32'h0, dout:32'h0,
                  vld:4'h0, err:4'h0, perr:4'h0, busy:0, prop:1};
            apply(1'b1, t, "rearm_idle");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
